// File: rtl/ram_to_uart_tx_pkg.sv
// ram_to_uart_tx_pkg: shared FSM encoding and UART framing constants
package ram_to_uart_tx_pkg;
  localparam int UART_FRAME_BITS = 10;
  localparam int DEFAULT_CLKS_PER_BIT = 5208;
  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, LOAD, SEND, DONE} state_e;
endpackage

// File: rtl/ram_to_uart_tx_if.sv
// ram_to_uart_tx_if: RAM read port shared between the dumper and the memory
interface ram_to_uart_tx_if #(
  parameter int ADDR_WIDTH = 16
);
  logic [ADDR_WIDTH-1:0] ramAddr;
  logic ramReadEnable;
  logic [7:0] ramDataIn;
  modport master (output ramAddr, output ramReadEnable, input ramDataIn);
  modport slave (input ramAddr, input ramReadEnable, output ramDataIn);
endinterface

// File: rtl/ram_to_uart_tx_serializer.sv
// ram_to_uart_tx_serializer: 8N1 LSB-first UART transmitter with one-cycle done pulse
module ram_to_uart_tx_serializer
  import ram_to_uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       txStart,
  input  logic [7:0] txData,
  output logic       txOut,
  output logic       txDone,
  output logic       txBusy
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST_TICK = CW'(CLKS_PER_BIT - 1);
  localparam logic [3:0] LAST_BIT = 4'(UART_FRAME_BITS - 1);
  logic [CW-1:0] cnt_q;
  logic [3:0] idx_q;
  logic [UART_FRAME_BITS-1:0] shift_q;
  logic busy_q;
  logic bit_end;
  assign bit_end = busy_q && cnt_q == LAST_TICK;
  assign txDone = bit_end && idx_q == LAST_BIT;
  assign txOut = shift_q[0];
  assign txBusy = busy_q;
  always_ff @(posedge clk)
    if (reset) begin
      busy_q <= 1'b0;
      cnt_q <= '0;
      idx_q <= '0;
      shift_q <= '1;
    end else if (!busy_q) begin
      if (txStart) begin
        busy_q <= 1'b1;
        cnt_q <= '0;
        idx_q <= '0;
        shift_q <= {1'b1, txData, 1'b0};
      end
    end else if (bit_end) begin
      cnt_q <= '0;
      idx_q <= idx_q + 4'd1;
      shift_q <= {1'b1, shift_q[UART_FRAME_BITS-1:1]};
      busy_q <= !txDone;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
endmodule

// File: rtl/ram_to_uart_tx.sv
// ram_to_uart_tx: dumps NUM_WORDS RAM bytes from BASE_ADDR over a UART TX line
module ram_to_uart_tx
  import ram_to_uart_tx_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
  parameter int NUM_WORDS = 256,
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  ram_to_uart_tx_if.master ram,
  output logic txOut,
  output logic busy,
  output logic RAM2UARTCompleted
);
  localparam logic [ADDR_WIDTH:0] LAST_CNT = (ADDR_WIDTH + 1)'(NUM_WORDS - 1);
  state_e state_q;
  logic [ADDR_WIDTH:0] count_q;
  logic [ADDR_WIDTH-1:0] ram_addr_q;
  logic [7:0] byte_q;
  logic ram_re_q, busy_q, done_q, tx_start_q;
  logic tx_done, tx_busy;
  assign ram.ramAddr = ram_addr_q;
  assign ram.ramReadEnable = ram_re_q;
  assign busy = busy_q || tx_busy;
  assign RAM2UARTCompleted = done_q;
  always_ff @(posedge clk)
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
      ram_addr_q <= BASE_ADDR;
      byte_q <= '0;
      ram_re_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      tx_start_q <= 1'b0;
    end else begin
      ram_re_q <= 1'b0;
      tx_start_q <= 1'b0;
      case (state_q)
        IDLE, DONE:
          if (start) begin
            state_q <= RD_REQ;
            count_q <= '0;
            ram_addr_q <= BASE_ADDR;
            ram_re_q <= 1'b1;
            busy_q <= 1'b1;
            done_q <= 1'b0;
          end
        RD_REQ: state_q <= RD_WAIT;
        RD_WAIT: begin
          state_q <= LOAD;
          byte_q <= ram.ramDataIn;
          tx_start_q <= 1'b1;
        end
        LOAD: state_q <= SEND;
        SEND:
          if (tx_done) begin
            if (count_q == LAST_CNT) begin
              state_q <= DONE;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              state_q <= RD_REQ;
              count_q <= count_q + (ADDR_WIDTH + 1)'(1);
              ram_addr_q <= ram_addr_q + ADDR_WIDTH'(1);
              ram_re_q <= 1'b1;
            end
          end
        default: state_q <= IDLE;
      endcase
    end
  ram_to_uart_tx_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk(clk),
    .reset(reset),
    .txStart(tx_start_q),
    .txData(byte_q),
    .txOut(txOut),
    .txDone(tx_done),
    .txBusy(tx_busy)
  );
endmodule

// File: tb/tb_ram_to_uart_tx.sv
// tb_ram_to_uart_tx: directed checks of the RAM-to-UART dumper with a 1-cycle-read RAM model
module tb_ram_to_uart_tx;
  localparam int CPB = 4;
  logic clk = 1'b0;
  logic reset, start_a, start_b, sel;
  logic tx_a, busy_a, comp_a, tx_b, busy_b, comp_b;
  logic v_line, v_re, v_busy, v_comp;
  logic [15:0] v_addr;
  int total = 0;
  int bad = 0;
  logic line_log[$];
  logic busy_log[$];
  logic comp_log[$];
  logic [15:0] rd_addr[$];
  int rd_idx[$];
  int done_idx;
  logic [7:0] exp_byte[$];
  logic [15:0] exp_addr[$];
  logic [39:0] first_vec;
  ram_to_uart_tx_if #(.ADDR_WIDTH(16)) ifa ();
  ram_to_uart_tx_if #(.ADDR_WIDTH(16)) ifb ();
  ram_to_uart_tx #(.ADDR_WIDTH(16), .BASE_ADDR(16'h0010), .NUM_WORDS(3), .CLKS_PER_BIT(CPB)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .ram(ifa),
    .txOut(tx_a), .busy(busy_a), .RAM2UARTCompleted(comp_a)
  );
  ram_to_uart_tx #(.ADDR_WIDTH(16), .BASE_ADDR(16'hFFFF), .NUM_WORDS(2), .CLKS_PER_BIT(CPB)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .ram(ifb),
    .txOut(tx_b), .busy(busy_b), .RAM2UARTCompleted(comp_b)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] mem_a(input logic [15:0] a);
    case (a)
      16'h0010: return 8'hA5;
      16'h0011: return 8'h3C;
      16'h0012: return 8'hFF;
      default: return 8'h00;
    endcase
  endfunction
  function automatic logic [7:0] mem_b(input logic [15:0] a);
    case (a)
      16'hFFFF: return 8'h5A;
      16'h0000: return 8'hC3;
      default: return 8'h00;
    endcase
  endfunction
  always @(posedge clk) if (ifa.ramReadEnable) ifa.ramDataIn <= mem_a(ifa.ramAddr);
  always @(posedge clk) if (ifb.ramReadEnable) ifb.ramDataIn <= mem_b(ifb.ramAddr);
  always_comb begin
    v_line = sel ? tx_b : tx_a;
    v_re = sel ? ifb.ramReadEnable : ifa.ramReadEnable;
    v_busy = sel ? busy_b : busy_a;
    v_comp = sel ? comp_b : comp_a;
    v_addr = sel ? ifb.ramAddr : ifa.ramAddr;
  end
  function automatic logic [39:0] frame_model(input logic [7:0] d);
    logic [9:0] bits;
    logic [39:0] v;
    bits = {1'b1, d, 1'b0};
    for (int t = 0; t < 40; t++) v[t] = bits[t / CPB];
    return v;
  endfunction
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic record(input int mid);
    line_log.delete();
    busy_log.delete();
    comp_log.delete();
    rd_addr.delete();
    rd_idx.delete();
    done_idx = -1;
    for (int i = 0; i < 400 && (done_idx < 0 || i < done_idx + 3); i++) begin
      @(negedge clk);
      line_log.push_back(v_line);
      busy_log.push_back(v_busy);
      comp_log.push_back(v_comp);
      if (v_re) begin
        rd_addr.push_back(v_addr);
        rd_idx.push_back(i);
      end
      if (v_comp && done_idx < 0) done_idx = i;
      start_a = !sel && i == mid;
      start_b = sel && i == mid;
    end
    chk("completed seen within budget", done_idx >= 0, 1);
  endtask
  task automatic analyze(input string tag);
    int starts[$];
    logic [39:0] vecs[$];
    logic [39:0] v;
    logic [7:0] d;
    int i;
    int n;
    i = 0;
    n = exp_byte.size();
    while (i < line_log.size()) begin
      if (line_log[i] == 1'b0 && i + 40 <= line_log.size()) begin
        for (int t = 0; t < 40; t++) v[t] = line_log[i + t];
        starts.push_back(i);
        vecs.push_back(v);
        i += 40;
      end else begin
        i++;
      end
    end
    if (vecs.size() > 0) first_vec = vecs[0];
    chk($sformatf("%s frame count", tag), starts.size(), n);
    chk($sformatf("%s read count", tag), rd_addr.size(), n);
    for (int k = 0; k < n; k++) begin
      if (k < starts.size()) begin
        for (int b = 0; b < 8; b++) d[b] = vecs[k][CPB * (b + 1)];
        chk($sformatf("%s frame%0d byte", tag, k), d, exp_byte[k]);
        chk($sformatf("%s frame%0d bits", tag, k), vecs[k], frame_model(exp_byte[k]));
        chk($sformatf("%s frame%0d start cycle", tag, k), starts[k], 3 + 43 * k);
      end
      if (k < rd_addr.size()) begin
        chk($sformatf("%s read%0d addr", tag, k), rd_addr[k], exp_addr[k]);
        chk($sformatf("%s read%0d cycle", tag, k), rd_idx[k], 43 * k);
      end
    end
    chk($sformatf("%s completed cycle", tag), done_idx, 43 * n);
    chk($sformatf("%s busy after start", tag), busy_log[0], 1);
    chk($sformatf("%s completed cleared", tag), comp_log[0], 0);
    if (done_idx > 0) begin
      chk($sformatf("%s busy in done", tag), busy_log[done_idx], 0);
      chk($sformatf("%s busy in last stop", tag), busy_log[done_idx - 1], 1);
    end
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    sel = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset txOut", tx_a, 1);
    chk("reset busy", busy_a, 0);
    chk("reset read enable", ifa.ramReadEnable, 0);
    chk("reset completed", comp_a, 0);
    chk("reset addr a", ifa.ramAddr, 16'h0010);
    chk("reset addr b", ifb.ramAddr, 16'hFFFF);
    reset = 1'b0;
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    for (int i = 0; i < 20 && tx_a; i++) @(negedge clk);
    chk("t1 line low before reset", tx_a, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("t1 txOut", tx_a, 1);
    chk("t1 busy", busy_a, 0);
    chk("t1 read enable", ifa.ramReadEnable, 0);
    chk("t1 completed", comp_a, 0);
    reset = 1'b0;
    @(negedge clk);
    exp_byte = '{8'hA5, 8'h3C, 8'hFF};
    exp_addr = '{16'h0010, 16'h0011, 16'h0012};
    start_a = 1'b1;
    record(-1);
    analyze("t2");
    chk("t3 A5 line pattern", first_vec, 40'hFF0F00F0F0);
    start_a = 1'b1;
    record(60);
    analyze("t4");
    chk("t5 completed held", comp_a, 1);
    start_a = 1'b1;
    record(-1);
    analyze("t5");
    sel = 1'b1;
    @(negedge clk);
    exp_byte = '{8'h5A, 8'hC3};
    exp_addr = '{16'hFFFF, 16'h0000};
    start_b = 1'b1;
    record(-1);
    analyze("t6");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
